clk_div_cfg_ctrl: RTL and testbench

//   Run-time configuration controller for one integer clock divider, in the divider's reference-clock domain.

---
 rtl/clk_div_cfg_ctrl.sv | 167 ++++++++++++++++
 tb/tb_clk_div_cfg_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_cfg_ctrl.sv
// clk_div_cfg_ctrl: run-time ratio/enable controller for one integer clock
// divider. Ratio changes and disables are deferred to a divided-period
// boundary, followed by a settle window with the divider held off, so the
// divided clock never produces a runt pulse while being reconfigured.
module clk_div_cfg_ctrl #(
  parameter int RATIO_WD    = 8,
  parameter int RESET_RATIO = 8,
  parameter int SETTLE_CYC  = 4
) (
  input  logic                i_ref_clk,
  input  logic                i_rst_n,
  input  logic                i_div_en_req,
  input  logic                i_cfg_valid,
  input  logic [RATIO_WD-1:0] i_cfg_ratio,
  output logic                o_cfg_ready,
  output logic                o_cfg_done,
  output logic                o_cfg_err,
  output logic [RATIO_WD-1:0] o_div_ratio,
  output logic                o_div_clk_en,
  output logic                o_busy
);

  localparam int                  SCNT_WD   = $clog2(SETTLE_CYC + 1);
  localparam logic [SCNT_WD-1:0]  SCNT_LAST = SCNT_WD'(SETTLE_CYC - 1);
  localparam logic [RATIO_WD-1:0] RATIO_RST = RATIO_WD'(RESET_RATIO);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RUN,
    ST_DRAIN,
    ST_SETTLE
  } state_t;

  state_t              state, state_nxt;
  logic [RATIO_WD-1:0] pcnt, pcnt_nxt;
  logic [RATIO_WD-1:0] ratio_nxt;
  logic [RATIO_WD-1:0] pend_ratio, pend_ratio_nxt;
  logic                pend_vld, pend_vld_nxt;
  logic [SCNT_WD-1:0]  scnt, scnt_nxt;
  logic                en_nxt;
  logic                done_nxt;
  logic                err_nxt;

  logic                xfer;
  logic                cfg_legal;
  logic [RATIO_WD-1:0] ratio_last;
  logic                period_end;
  logic                settle_end;

  // Requests are only taken while the divider ratio is stable (OFF or RUN)
  assign o_cfg_ready = (state == ST_OFF) || (state == ST_RUN);
  assign o_busy      = (state == ST_DRAIN) || (state == ST_SETTLE);
  assign xfer        = i_cfg_valid & o_cfg_ready;
  assign cfg_legal   = xfer & (i_cfg_ratio != '0);
  // o_div_ratio is never 0, so the subtraction cannot wrap
  assign ratio_last  = o_div_ratio - RATIO_WD'(1);
  assign period_end  = (pcnt == ratio_last);
  assign settle_end  = (scnt == SCNT_LAST);

  // Next-state and next-output decode for the reconfiguration sequence
  always_comb begin
    state_nxt      = state;
    pcnt_nxt       = pcnt;
    scnt_nxt       = scnt;
    ratio_nxt      = o_div_ratio;
    pend_vld_nxt   = pend_vld;
    pend_ratio_nxt = pend_ratio;
    en_nxt         = o_div_clk_en;
    done_nxt       = 1'b0;
    err_nxt        = xfer & (i_cfg_ratio == '0);

    case (state)
      ST_OFF: begin
        en_nxt = 1'b0;
        // Divider is stopped, so a new ratio can be applied directly
        if (cfg_legal) begin
          ratio_nxt = i_cfg_ratio;
          done_nxt  = 1'b1;
        end
        if (i_div_en_req) begin
          state_nxt = ST_RUN;
          en_nxt    = 1'b1;
          pcnt_nxt  = '0;
        end
      end

      ST_RUN: begin
        en_nxt   = 1'b1;
        pcnt_nxt = period_end ? '0 : pcnt + RATIO_WD'(1);
        if (cfg_legal) begin
          if (i_cfg_ratio == o_div_ratio) begin
            done_nxt = 1'b1;
          end else begin
            pend_vld_nxt   = 1'b1;
            pend_ratio_nxt = i_cfg_ratio;
            state_nxt      = ST_DRAIN;
          end
        end
        // A disable and a ratio change in the same cycle share one drain
        if (!i_div_en_req) begin
          state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        pcnt_nxt = period_end ? '0 : pcnt + RATIO_WD'(1);
        // Stop the divider exactly at the end of its current period
        if (period_end) begin
          en_nxt    = 1'b0;
          scnt_nxt  = '0;
          state_nxt = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        en_nxt   = 1'b0;
        scnt_nxt = scnt + SCNT_WD'(1);
        if (settle_end) begin
          scnt_nxt = '0;
          if (pend_vld) begin
            ratio_nxt    = pend_ratio;
            done_nxt     = 1'b1;
            pend_vld_nxt = 1'b0;
          end
          if (i_div_en_req) begin
            state_nxt = ST_RUN;
            en_nxt    = 1'b1;
            pcnt_nxt  = '0;
          end else begin
            state_nxt = ST_OFF;
          end
        end
      end

      default: begin
        state_nxt = ST_OFF;
        en_nxt    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any pending ratio
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_OFF;
      pcnt         <= '0;
      scnt         <= '0;
      o_div_ratio  <= RATIO_RST;
      pend_vld     <= 1'b0;
      pend_ratio   <= '0;
      o_div_clk_en <= 1'b0;
      o_cfg_done   <= 1'b0;
      o_cfg_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      pcnt         <= pcnt_nxt;
      scnt         <= scnt_nxt;
      o_div_ratio  <= ratio_nxt;
      pend_vld     <= pend_vld_nxt;
      pend_ratio   <= pend_ratio_nxt;
      o_div_clk_en <= en_nxt;
      o_cfg_done   <= done_nxt;
      o_cfg_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Testbench for clk_div_cfg_ctrl: scenario tasks with inline checks plus a
// scoreboard queue that pairs every accepted request with its done/err pulse.
`timescale 1ns/1ps
module tb_clk_div_cfg_ctrl;

  localparam int RATIO_WD    = 8;
  localparam int RESET_RATIO = 8;
  localparam int SETTLE_CYC  = 4;

  logic                clk       = 1'b0;
  logic                rst_n     = 1'b0;
  logic                en_req    = 1'b0;
  logic                cfg_valid = 1'b0;
  logic [RATIO_WD-1:0] cfg_ratio = '0;
  logic                cfg_ready;
  logic                cfg_done;
  logic                cfg_err;
  logic [RATIO_WD-1:0] div_ratio;
  logic                div_clk_en;
  logic                busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic                is_err;
    logic [RATIO_WD-1:0] ratio;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  clk_div_cfg_ctrl #(
    .RATIO_WD   (RATIO_WD),
    .RESET_RATIO(RESET_RATIO),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_div_en_req(en_req),
    .i_cfg_valid (cfg_valid),
    .i_cfg_ratio (cfg_ratio),
    .o_cfg_ready (cfg_ready),
    .o_cfg_done  (cfg_done),
    .o_cfg_err   (cfg_err),
    .o_div_ratio (div_ratio),
    .o_div_clk_en(div_clk_en),
    .o_busy      (busy)
  );

  // Scoreboard: every done/err pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && (cfg_done === 1'b1 || cfg_err === 1'b1)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_pulse: got done=%b err=%b ratio=%0d, want no pulse",
                 cfg_done, cfg_err, div_ratio);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({cfg_err, cfg_done, div_ratio} !== {e.is_err, ~e.is_err, e.ratio}) begin
          miscompares++;
          $display("FAIL sb_pulse: got err=%b done=%b ratio=%0d, want err=%b done=%b ratio=%0d",
                   cfg_err, cfg_done, div_ratio, e.is_err, ~e.is_err, e.ratio);
        end
      end
    end
  end

  // Presents one request for one cycle; cur is the ratio expected to remain on error
  task automatic drive_cfg(input logic [RATIO_WD-1:0] r, input logic [RATIO_WD-1:0] cur);
    exp_t e;
    cfg_valid = 1'b1;
    cfg_ratio = r;
    if (cfg_ready === 1'b1) begin
      e.is_err = (r == '0);
      e.ratio  = (r == '0) ? cur : r;
      sb.push_back(e);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_ratio = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_req = 1'b0; cfg_valid = 1'b0; cfg_ratio = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({div_ratio, div_clk_en, cfg_done, cfg_err, busy, cfg_ready} !== {8'd8, 5'b00001}) begin
      miscompares++;
      $display("FAIL reset_state: got ratio=%0d en=%b done=%b err=%b busy=%b ready=%b, want 8 0 0 0 0 1",
               div_ratio, div_clk_en, cfg_done, cfg_err, busy, cfg_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_off_cfg();
    drive_cfg(8'd6, 8'd8);
    vectors++;
    if ({div_ratio, cfg_done, div_clk_en} !== {8'd6, 2'b10}) begin
      miscompares++;
      $display("FAIL off_cfg_apply: got ratio=%0d done=%b en=%b, want 6 1 0",
               div_ratio, cfg_done, div_clk_en);
    end
    @(negedge clk);
    vectors++;
    if ({div_ratio, cfg_done, div_clk_en} !== {8'd6, 2'b00}) begin
      miscompares++;
      $display("FAIL off_cfg_after: got ratio=%0d done=%b en=%b, want 6 0 0",
               div_ratio, cfg_done, div_clk_en);
    end
  endtask

  task automatic test_run_change();
    drive_cfg(8'd4, 8'd6);
    en_req = 1'b1;
    @(negedge clk);
    vectors++;
    if ({div_clk_en, busy, div_ratio} !== {2'b10, 8'd4}) begin
      miscompares++;
      $display("FAIL run_enter: got en=%b busy=%b ratio=%0d, want 1 0 4", div_clk_en, busy, div_ratio);
    end
    @(negedge clk);
    drive_cfg(8'd5, 8'd4);
    vectors++;
    if ({cfg_ready, busy, div_clk_en, div_ratio} !== {3'b011, 8'd4}) begin
      miscompares++;
      $display("FAIL drain_start: got ready=%b busy=%b en=%b ratio=%0d, want 0 1 1 4",
               cfg_ready, busy, div_clk_en, div_ratio);
    end
    @(negedge clk);
    vectors++;
    if (div_clk_en !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_last_period: got en=%b, want 1", div_clk_en);
    end
    for (int i = 0; i < SETTLE_CYC; i++) begin
      @(negedge clk);
      vectors++;
      if ({div_clk_en, busy, cfg_ready, cfg_done} !== 4'b0100) begin
        miscompares++;
        $display("FAIL settle_%0d: got en=%b busy=%b ready=%b done=%b, want 0 1 0 0",
                 i, div_clk_en, busy, cfg_ready, cfg_done);
      end
    end
    @(negedge clk);
    vectors++;
    if ({div_clk_en, div_ratio, cfg_done, busy} !== {1'b1, 8'd5, 2'b10}) begin
      miscompares++;
      $display("FAIL change_apply: got en=%b ratio=%0d done=%b busy=%b, want 1 5 1 0",
               div_clk_en, div_ratio, cfg_done, busy);
    end
  endtask

  task automatic test_same_ratio();
    drive_cfg(8'd5, 8'd5);
    vectors++;
    if ({cfg_done, busy, div_clk_en, cfg_ready} !== 4'b1011) begin
      miscompares++;
      $display("FAIL same_ratio_done: got done=%b busy=%b en=%b ready=%b, want 1 0 1 1",
               cfg_done, busy, div_clk_en, cfg_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if ({div_clk_en, busy, div_ratio} !== {2'b10, 8'd5}) begin
        miscompares++;
        $display("FAIL same_ratio_hold_%0d: got en=%b busy=%b ratio=%0d, want 1 0 5",
                 i, div_clk_en, busy, div_ratio);
      end
    end
  endtask

  task automatic test_cfg_err();
    drive_cfg(8'd0, 8'd5);
    vectors++;
    if ({cfg_err, cfg_done, div_clk_en, div_ratio} !== {3'b101, 8'd5}) begin
      miscompares++;
      $display("FAIL err_pulse: got err=%b done=%b en=%b ratio=%0d, want 1 0 1 5",
               cfg_err, cfg_done, div_clk_en, div_ratio);
    end
    @(negedge clk);
    vectors++;
    if ({cfg_err, cfg_done, div_clk_en, busy} !== 4'b0010) begin
      miscompares++;
      $display("FAIL err_after: got err=%b done=%b en=%b busy=%b, want 0 0 1 0",
               cfg_err, cfg_done, div_clk_en, busy);
    end
  endtask

  task automatic test_simul_change();
    bit seen;
    seen = 1'b0;
    drive_cfg(8'd3, 8'd5);
    for (int i = 0; i < 30 && !seen; i++) begin
      if (cfg_done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!seen || {div_ratio, div_clk_en} !== {8'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL ratio3_apply: got seen=%b ratio=%0d en=%b, want 1 3 1", seen, div_ratio, div_clk_en);
    end
    // Entry cycle is period phase 0; four more cycles puts phase at 1 of 3
    repeat (4) @(negedge clk);
    en_req = 1'b0;
    drive_cfg(8'd7, 8'd3);
    vectors++;
    if ({div_clk_en, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL simul_drain: got en=%b busy=%b, want 1 1", div_clk_en, busy);
    end
    for (int i = 0; i < SETTLE_CYC; i++) begin
      @(negedge clk);
      vectors++;
      if ({div_clk_en, busy, div_ratio} !== {2'b01, 8'd3}) begin
        miscompares++;
        $display("FAIL simul_settle_%0d: got en=%b busy=%b ratio=%0d, want 0 1 3",
                 i, div_clk_en, busy, div_ratio);
      end
    end
    @(negedge clk);
    vectors++;
    if ({div_ratio, cfg_done, div_clk_en, busy, cfg_ready} !== {8'd7, 4'b1001}) begin
      miscompares++;
      $display("FAIL simul_exit_off: got ratio=%0d done=%b en=%b busy=%b ready=%b, want 7 1 0 0 1",
               div_ratio, cfg_done, div_clk_en, busy, cfg_ready);
    end
    @(negedge clk);
    vectors++;
    if ({div_clk_en, cfg_done} !== 2'b00) begin
      miscompares++;
      $display("FAIL simul_off_hold: got en=%b done=%b, want 0 0", div_clk_en, cfg_done);
    end
  endtask

  task automatic test_ratio_one();
    drive_cfg(8'd1, 8'd7);
    en_req = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({div_ratio, div_clk_en, busy} !== {8'd1, 2'b10}) begin
      miscompares++;
      $display("FAIL bypass_run: got ratio=%0d en=%b busy=%b, want 1 1 0", div_ratio, div_clk_en, busy);
    end
    en_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({div_clk_en, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL bypass_drain: got en=%b busy=%b, want 1 1", div_clk_en, busy);
    end
    @(negedge clk);
    vectors++;
    if ({div_clk_en, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL bypass_drain_end: got en=%b busy=%b, want 0 1", div_clk_en, busy);
    end
    repeat (SETTLE_CYC) @(negedge clk);
    vectors++;
    if ({div_clk_en, busy, cfg_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL bypass_off: got en=%b busy=%b ready=%b, want 0 0 1", div_clk_en, busy, cfg_ready);
    end
  endtask

  task automatic test_reset_mid();
    en_req = 1'b1;
    @(negedge clk);
    drive_cfg(8'd3, 8'd1);
    repeat (2) @(negedge clk);
    vectors++;
    if ({div_clk_en, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL pre_reset_settle: got en=%b busy=%b, want 0 1", div_clk_en, busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({div_ratio, div_clk_en, busy, cfg_done, cfg_ready} !== {8'd8, 4'b0001}) begin
      miscompares++;
      $display("FAIL async_reset: got ratio=%0d en=%b busy=%b done=%b ready=%b, want 8 0 0 0 1",
               div_ratio, div_clk_en, busy, cfg_done, cfg_ready);
    end
    sb.delete();
    en_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if ({div_ratio, div_clk_en, cfg_done} !== {8'd8, 2'b00}) begin
        miscompares++;
        $display("FAIL post_reset_%0d: got ratio=%0d en=%b done=%b, want 8 0 0",
                 i, div_ratio, div_clk_en, cfg_done);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_off_cfg();
    test_run_change();
    test_same_ratio();
    test_cfg_err();
    test_simul_change();
    test_ratio_one();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drained: got %0d outstanding requests, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
